oled_spi_rx_monitor: RTL

//  Receive-side decoder for the OLED SPI link (spi clk/data/dc_n) driven by oledControl.

---
 rtl/oled_spi_rx_monitor.sv | 108 ++++++++++
 1 files changed

// File: rtl/oled_spi_rx_monitor.sv
// oled_spi_rx_monitor: oversampled SPI byte decoder with command/data tags, FWFT FIFO and link statistics
module oled_spi_rx_monitor #(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT     = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        spi_clk,
    input  logic        spi_data,
    input  logic        spi_dc_n,
    input  logic        oled_reset_n,
    output logic [7:0]  rx_data,
    output logic        rx_is_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        overflow,
    output logic        framing_err,
    output logic [15:0] data_count,
    output logic [15:0] cmd_count,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [3:0]    sync_q [SYNC_STAGES];
    logic [3:0]    sync_d [SYNC_STAGES];
    logic [8:0]    mem_q [DEPTH];
    logic [8:0]    mem_d [DEPTH];
    logic [3:0]    s;
    logic          sclk_prev_q, sclk_prev_d, sclk_rise, timeout, done, pop, full, push;
    logic [6:0]    shreg_q, shreg_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [8:0]    head_q, head_d;
    logic          rx_valid_q, rx_valid_d, overflow_q, overflow_d, ferr_q, ferr_d;
    logic [15:0]   data_count_q, data_count_d, cmd_count_q, cmd_count_d;

    always_comb begin
        sync_d[0] = {oled_reset_n, spi_dc_n, spi_data, spi_clk};
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        s = sync_q[SYNC_STAGES-1];
        sclk_prev_d = s[0];
        // panel reset (s[3] low) masks edges and drops any partial byte
        sclk_rise = s[0] & ~sclk_prev_q & s[3];
        timeout = bit_cnt_q != 3'd0 && !sclk_rise && idle_q == IW'(TIMEOUT - 1);
        done = sclk_rise && bit_cnt_q == 3'd7;
        shreg_d = sclk_rise ? {shreg_q[5:0], s[1]} : shreg_q;
        bit_cnt_d = (!s[3] || timeout) ? 3'd0 : bit_cnt_q + 3'(sclk_rise);
        idle_d = (!s[3] || timeout || sclk_rise || bit_cnt_q == 3'd0) ? '0 : idle_q + 1'b1;
        pop = rx_valid_q & rx_ready;
        full = (wr_q - rd_q) == (AW+1)'(DEPTH);
        push = done && (!full || pop);
        mem_d = mem_q;
        if (push) mem_d[wr_q[AW-1:0]] = {s[2], shreg_q, s[1]};
        wr_d = wr_q + (AW+1)'(push);
        rd_d = rd_q + (AW+1)'(pop);
        // head registers only see entries committed before this cycle
        rx_valid_d = wr_q != rd_d;
        head_d = mem_q[rd_d[AW-1:0]];
        overflow_d = overflow_q | (done & full & ~pop);
        ferr_d = ferr_q | timeout;
        data_count_d = data_count_q + 16'(done && s[2] && data_count_q != 16'hFFFF);
        cmd_count_d = cmd_count_q + 16'(done && !s[2] && cmd_count_q != 16'hFFFF);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            sclk_prev_q  <= 1'b0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            idle_q       <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            head_q       <= '0;
            rx_valid_q   <= 1'b0;
            overflow_q   <= 1'b0;
            ferr_q       <= 1'b0;
            data_count_q <= '0;
            cmd_count_q  <= '0;
        end else begin
            sync_q       <= sync_d;
            mem_q        <= mem_d;
            sclk_prev_q  <= sclk_prev_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            idle_q       <= idle_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            head_q       <= head_d;
            rx_valid_q   <= rx_valid_d;
            overflow_q   <= overflow_d;
            ferr_q       <= ferr_d;
            data_count_q <= data_count_d;
            cmd_count_q  <= cmd_count_d;
        end
    end

    assign {rx_is_data, rx_data} = head_q;
    assign rx_valid    = rx_valid_q;
    assign overflow    = overflow_q;
    assign framing_err = ferr_q;
    assign data_count  = data_count_q;
    assign cmd_count   = cmd_count_q;
    assign busy        = bit_cnt_q != 3'd0;
endmodule
